// File: rtl/mult_div_unit.sv
// Iterative signed MULT/DIV with architectural HI/LO. Result lands WIDTH+1 cycles after an accepted start.
// While busy, new starts are ignored and stall holds any MULT/DIV/MFHI/MFLO in EX.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_hilo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               op_r;
  logic               neg_res;
  logic               neg_rem;
  logic               div0;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   a_back;

  assign a_abs = a[WIDTH-1] ? -a : a;
  assign b_abs = b[WIDTH-1] ? -b : b;

  // MULT: acc = {partial sum, remaining multiplier bits}, shifted right each step.
  // DIV:  acc = {partial remainder, dividend/quotient bits}, shifted left each step.
  always_comb begin
    addend   = acc[0] ? mag_a : '0;
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    div_diff = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {2'b00, mag_b};
    if (op_r) begin
      if (div_diff[WIDTH+1]) acc_next = {acc[2*WIDTH-2:0], 1'b0};
      else                   acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
    prod   = neg_res ? -acc : acc;
    quo    = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    // Divide-by-zero returns the original dividend in HI, rebuilt from magnitude and sign.
    a_back = neg_rem ? -mag_a : mag_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op_r    <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
      acc     <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CALC;
            cnt     <= '0;
            op_r    <= op;
            mag_a   <= a_abs;
            mag_b   <= b_abs;
            neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem <= a[WIDTH-1];
            div0    <= (b == '0);
            acc     <= op ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          if (!op_r) begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end else if (div0) begin
            hi <= a_back;
            lo <= '1;
          end else begin
            hi <= rem;
            lo <= quo;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign stall = busy & (start | rd_hilo);

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI:LO pushed at issue, popped and compared on done.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         rd_hilo;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         stall;
  logic         done;

  int          checks = 0;
  int          passes = 0;
  logic [63:0] sb[$];
  logic [63:0] last_hilo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .rd_hilo(rd_hilo), .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
    int     q;
    int     r;
    if (!o) begin
      p = longint'($signed(x)) * longint'($signed(y));
      return p;
    end
    if (y == 32'h0) return {x, 32'hFFFF_FFFF};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    q = $signed(x) / $signed(y);
    r = $signed(x) % $signed(y);
    return {r, q};
  endfunction

  // Presents one op for a single cycle; caller guarantees the unit is idle.
  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    sb.push_back(model(o, x, y));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output int busy_cycles);
    seen = 1'b0;
    busy_cycles = busy ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0; rd_hilo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({hi, lo} !== 64'h0) $display("FAIL reset_hilo: got %h, expected 0", {hi, lo});
    else passes++;
    checks++;
    if ({busy, stall, done} !== 3'b000) $display("FAIL reset_flags: busy/stall/done got %b, expected 000", {busy, stall, done});
    else passes++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b, expected 0", busy);
    else passes++;
  endtask

  task automatic test_mult();
    logic [W-1:0] xs [5];
    logic [W-1:0] ys [5];
    logic [63:0]  exp;
    bit           seen;
    int           bc;
    xs = '{32'd7, 32'h0000_1234, 32'hFFFF_FF00, 32'h0, 32'h0};
    ys = '{32'hFFFF_FFFD, 32'h0000_5678, 32'hFFFF_FF00, 32'h0, 32'h0};
    xs[3] = $urandom(); ys[3] = $urandom();
    xs[4] = $urandom(); ys[4] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, xs[i], ys[i]);
      wait_done(seen, bc);
      exp = sb.pop_front();
      checks++;
      if (!seen || {hi, lo} !== exp)
        $display("FAIL mult[%0d]: got hi:lo=%h done_seen=%0b, expected %h", i, {hi, lo}, seen, exp);
      else passes++;
      last_hilo = exp;
      if (i == 0) begin
        checks++;
        if (bc !== 33) $display("FAIL mult_busy_cycles: got %0d, expected 33", bc);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) $display("FAIL mult_done_pulse: done got %b one cycle later, expected 0", done);
        else passes++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    bit          seen;
    int          bc;
    issue(1'b0, 32'h8000_0000, 32'h8000_0000);
    wait_done(seen, bc);
    start = 1'b1; op = 1'b0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; #1;
    checks++;
    if (stall !== 1'b0) $display("FAIL b2b_stall_idle: got %b, expected 0", stall);
    else passes++;
    exp = sb.pop_front();
    checks++;
    if (!seen || {hi, lo} !== exp) $display("FAIL b2b_first: got %h seen=%0b, expected %h", {hi, lo}, seen, exp);
    else passes++;
    last_hilo = exp;
    sb.push_back(model(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("FAIL b2b_accept: busy got %b, expected 1", busy);
    else passes++;
    wait_done(seen, bc);
    exp = sb.pop_front();
    checks++;
    if (!seen || {hi, lo} !== exp) $display("FAIL b2b_second: got %h seen=%0b, expected %h", {hi, lo}, seen, exp);
    else passes++;
    last_hilo = exp;
  endtask

  task automatic test_div();
    logic [W-1:0] xs [4];
    logic [W-1:0] ys [4];
    logic [63:0]  exp;
    bit           seen;
    int           bc;
    xs = '{32'hFFFF_FFF9, 32'd7, 32'h0, 32'h0};
    ys = '{32'd2, 32'hFFFF_FFFE, 32'h0, 32'h0};
    xs[2] = $urandom(); ys[2] = $urandom_range(1, 1000);
    xs[3] = $urandom(); ys[3] = 32'hFFFF_0000 | $urandom_range(1, 65535);
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, xs[i], ys[i]);
      wait_done(seen, bc);
      exp = sb.pop_front();
      checks++;
      if (!seen || {hi, lo} !== exp)
        $display("FAIL div[%0d]: got hi:lo=%h done_seen=%0b, expected %h", i, {hi, lo}, seen, exp);
      else passes++;
      last_hilo = exp;
    end
  endtask

  task automatic test_corner_div();
    logic [W-1:0] xs [4];
    logic [W-1:0] ys [4];
    logic [63:0]  exp;
    bit           seen;
    int           bc;
    xs = '{32'h8000_0000, 32'd5, 32'hFFFF_FFFB, 32'h0};
    ys = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'd3};
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, xs[i], ys[i]);
      wait_done(seen, bc);
      exp = sb.pop_front();
      checks++;
      if (!seen || {hi, lo} !== exp)
        $display("FAIL corner_div[%0d]: got hi:lo=%h done_seen=%0b, expected %h", i, {hi, lo}, seen, exp);
      else passes++;
      last_hilo = exp;
    end
  endtask

  task automatic test_holdoff();
    logic [63:0] exp;
    bit          seen;
    int          bc;
    int          bad;
    issue(1'b0, 32'd1234, 32'hFFFF_FFC8);
    @(posedge clk); #1;
    rd_hilo = 1'b1; #1;
    checks++;
    if (stall !== 1'b1 || {hi, lo} !== last_hilo)
      $display("FAIL hold_rd_hilo: stall=%b hi:lo=%h, expected stall=1 hi:lo=%h", stall, {hi, lo}, last_hilo);
    else passes++;
    rd_hilo = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7; #1;
    checks++;
    if (stall !== 1'b1) $display("FAIL hold_start_stall: got %b, expected 1", stall);
    else passes++;
    bad = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (stall !== 1'b1 || {hi, lo} !== last_hilo) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL hold_busy_cycles: %0d cycles with stall!=1 or hi:lo changed, expected 0", bad);
    else passes++;
    exp = sb.pop_front();
    checks++;
    if (!seen || {hi, lo} !== exp) $display("FAIL hold_mult_result: got %h seen=%0b, expected %h", {hi, lo}, seen, exp);
    else passes++;
    last_hilo = exp;
    checks++;
    if (stall !== 1'b0) $display("FAIL hold_release_stall: got %b, expected 0", stall);
    else passes++;
    sb.push_back(model(1'b1, 32'd100, 32'd7));
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(seen, bc);
    checks++;
    if (bc !== 33) $display("FAIL hold_second_busy: got %0d busy cycles, expected 33", bc);
    else passes++;
    exp = sb.pop_front();
    checks++;
    if (!seen || {hi, lo} !== exp) $display("FAIL hold_div_result: got %h seen=%0b, expected %h", {hi, lo}, seen, exp);
    else passes++;
    last_hilo = exp;
  endtask

  task automatic test_reset_mid();
    logic [63:0] exp;
    bit          seen;
    int          bc;
    issue(1'b1, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    rd_hilo = 1'b1; #1;
    checks++;
    if (busy !== 1'b1 || stall !== 1'b1) $display("FAIL mid_pre_reset: busy=%b stall=%b, expected 1 1", busy, stall);
    else passes++;
    rst_n = 1'b0; #1;
    checks++;
    if ({busy, stall, done} !== 3'b000 || {hi, lo} !== 64'h0)
      $display("FAIL mid_async_reset: busy/stall/done=%b hi:lo=%h, expected 000 and 0", {busy, stall, done}, {hi, lo});
    else passes++;
    sb.delete();
    last_hilo = '0;
    #1;
    rst_n = 1'b1; rd_hilo = 1'b0;
    @(posedge clk); #1;
    issue(1'b0, 32'd3, 32'd4);
    wait_done(seen, bc);
    exp = sb.pop_front();
    checks++;
    if (!seen || {hi, lo} !== exp || lo !== 32'd12)
      $display("FAIL mid_post_mult: got %h seen=%0b, expected %h", {hi, lo}, seen, exp);
    else passes++;
    last_hilo = exp;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_div();
    test_corner_div();
    test_holdoff();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
